// File: rtl/c17_resp_checker.sv
// Response checker for the c17 pattern-apply flow: compares each response to a golden table and reports pass/fail.
// Optional signature register enabled by defining C17_MISR_EN (adds output misr_sig).
module c17_resp_checker #(
  parameter int RESP_W  = 2,
  parameter int NUM_PAT = 32,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gold_we,
  input  logic [IDX_W-1:0]  gold_addr,
  input  logic [RESP_W-1:0] gold_data,
  input  logic              start,
  input  logic              abort,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              first_fail_vld,
  output logic [IDX_W-1:0]  first_fail_idx
`ifdef C17_MISR_EN
  ,
  output logic [15:0]       misr_sig
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [RESP_W-1:0]   gold_table_r [NUM_PAT];
  logic [IDX_W-1:0]    pat_idx_r;
  logic [CNT_W-1:0]    fail_cnt_r;
  logic                first_fail_vld_r;
  logic [IDX_W-1:0]    first_fail_idx_r;
  logic                accept_s;
  logic                last_s;
  logic                mismatch_s;
  logic                start_ok_s;
  logic                gold_wr_s;

  // A response that arrives together with abort is discarded.
  assign accept_s   = resp_valid && (state_r == RUN) && !abort;
  assign last_s     = (pat_idx_r == IDX_W'(NUM_PAT - 1));
  assign mismatch_s = accept_s && (resp_data != gold_table_r[pat_idx_r]);
  assign start_ok_s = start && !abort && (state_r != RUN);
  assign gold_wr_s  = gold_we && (state_r != RUN) &&
                      ({1'b0, gold_addr} < (IDX_W + 1)'(NUM_PAT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every other request.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = start ? RUN : IDLE;
        RUN:     state_s = (accept_s && last_s) ? DONE : RUN;
        DONE:    state_s = start ? RUN : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Status outputs decoded from registered state and results.
  always_comb begin
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      RUN: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      IDLE:    done = 1'b0;
      default: done = 1'b0;
    endcase
    if (done && (fail_cnt_r == {CNT_W{1'b0}})) begin
      pass = 1'b1;
    end else begin
      pass = 1'b0;
    end
  end

  // Golden table storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (gold_wr_s) begin
      gold_table_r[gold_addr] <= gold_data;
    end
  end

  // Pattern index, saturating mismatch count and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_idx_r        <= {IDX_W{1'b0}};
      fail_cnt_r       <= {CNT_W{1'b0}};
      first_fail_vld_r <= 1'b0;
      first_fail_idx_r <= {IDX_W{1'b0}};
    end else if (start_ok_s) begin
      pat_idx_r        <= {IDX_W{1'b0}};
      fail_cnt_r       <= {CNT_W{1'b0}};
      first_fail_vld_r <= 1'b0;
      first_fail_idx_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      if (!last_s) begin
        pat_idx_r <= pat_idx_r + IDX_W'(1);
      end
      if (mismatch_s) begin
        if (fail_cnt_r != {CNT_W{1'b1}}) begin
          fail_cnt_r <= fail_cnt_r + CNT_W'(1);
        end
        if (!first_fail_vld_r) begin
          first_fail_vld_r <= 1'b1;
          first_fail_idx_r <= pat_idx_r;
        end
      end
    end
  end

  assign fail_cnt       = fail_cnt_r;
  assign first_fail_vld = first_fail_vld_r;
  assign first_fail_idx = first_fail_idx_r;

`ifdef C17_MISR_EN
  logic [15:0] misr_r;

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [RESP_W-1:0] din);
    logic fb;
    fb = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
    return {sig[14:0], fb} ^ {{(16 - RESP_W){1'b0}}, din};
  endfunction

  // Signature accumulates every accepted response of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr_r <= 16'hFFFF;
    end else if (start_ok_s) begin
      misr_r <= 16'hFFFF;
    end else if (accept_s) begin
      misr_r <= misr_step(misr_r, resp_data);
    end
  end

  assign misr_sig = misr_r;
`endif

endmodule

// File: tb/tb_c17_resp_checker.sv
// Self-checking bench for c17_resp_checker: directed run sequence with random data against a table-based model.
module tb_c17_resp_checker;

  localparam int RESP_W  = 2;
  localparam int NUM_PAT = 32;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              gold_we;
  logic [IDX_W-1:0]  gold_addr;
  logic [RESP_W-1:0] gold_data;
  logic              start;
  logic              abort;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready, busy, done, pass, first_fail_vld;
  logic [CNT_W-1:0]  fail_cnt;
  logic [IDX_W-1:0]  first_fail_idx;
  logic              s_ready, s_busy, s_done, s_pass, s_ffv;
  logic [1:0]        s_fail_cnt;
  logic [IDX_W-1:0]  s_ffi;
`ifdef C17_MISR_EN
  logic [15:0]       misr_sig, s_misr;
`endif

  int checks = 0;
  int errors = 0;
  logic [RESP_W-1:0] gold_m [NUM_PAT];
  logic [RESP_W-1:0] resp_q [NUM_PAT];

  always #5 clk = ~clk;

  c17_resp_checker #(.RESP_W(RESP_W), .NUM_PAT(NUM_PAT), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .start(start), .abort(abort), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
`ifdef C17_MISR_EN
    , .misr_sig(misr_sig)
`endif
  );

  // Narrow-counter instance sharing the same stimulus to exercise saturation.
  c17_resp_checker #(.RESP_W(RESP_W), .NUM_PAT(NUM_PAT), .IDX_W(IDX_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .start(start), .abort(abort), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(s_ready), .busy(s_busy), .done(s_done), .pass(s_pass), .fail_cnt(s_fail_cnt),
    .first_fail_vld(s_ffv), .first_fail_idx(s_ffi)
`ifdef C17_MISR_EN
    , .misr_sig(s_misr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_gold(input bit random_tbl);
    for (int i = 0; i < NUM_PAT; i++) begin
      gold_m[i] = random_tbl ? RESP_W'($urandom_range(0, 3)) : RESP_W'(i % 4);
      gold_we   = 1'b1;
      gold_addr = IDX_W'(i);
      gold_data = gold_m[i];
      tick();
    end
    gold_we = 1'b0;
  endtask

  // Drives one run; abort_at < 0 means run to completion. Expected results come from the model table.
  task automatic do_run(input bit gaps, input int abort_at, input bit gold_poke);
    int idx = 0;
    int cyc = 0;
    int fails = 0;
    int ffi = 0;
    bit aborted = 1'b0;
    bit v;
`ifdef C17_MISR_EN
    logic [15:0] misr_m = 16'hFFFF;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cnt_clear_on_start", 32'(fail_cnt), 32'd0);
    chk("ffv_clear_on_start", 32'(first_fail_vld), 32'd0);
    while (idx < NUM_PAT && cyc < 1000) begin
      chk("busy_in_run", 32'(busy), 32'd1);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      resp_valid = v;
      resp_data  = resp_q[idx];
      if (abort_at >= 0 && idx == abort_at && v) abort = 1'b1;
      if (gold_poke && idx == 3) begin
        gold_we   = 1'b1;
        gold_addr = IDX_W'(0);
        gold_data = ~gold_m[0];
      end
      tick();
      gold_we = 1'b0;
      cyc++;
      if (abort) begin
        abort      = 1'b0;
        resp_valid = 1'b0;
        aborted    = 1'b1;
        break;
      end
`ifdef C17_MISR_EN
      if (v) misr_m = {misr_m[14:0], misr_m[15] ^ misr_m[14] ^ misr_m[12] ^ misr_m[3]} ^ {14'd0, resp_q[idx]};
`endif
      if (v) idx++;
    end
    resp_valid = 1'b0;
    chk("run_cycle_budget", 32'(cyc < 1000), 32'd1);
    for (int i = idx - 1; i >= 0; i--) begin
      if (resp_q[i] != gold_m[i]) begin
        fails++;
        ffi = i;
      end
    end
    chk("fail_cnt", 32'(fail_cnt), 32'(fails));
    chk("fail_cnt_sat", 32'(s_fail_cnt), 32'((fails > 3) ? 3 : fails));
    chk("first_fail_vld", 32'(first_fail_vld), 32'(fails != 0));
    chk("first_fail_idx", 32'(first_fail_idx), 32'(ffi));
    chk("done", 32'(done), 32'(!aborted));
    chk("pass", 32'(pass), 32'(!aborted && fails == 0));
    chk("busy_after_run", 32'(busy), 32'd0);
`ifdef C17_MISR_EN
    chk("misr_sig", 32'(misr_sig), 32'(misr_m));
`endif
  endtask

  initial begin
    rst_n = 1'b0; gold_we = 1'b0; gold_addr = '0; gold_data = '0;
    start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(resp_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_ffv", 32'(first_fail_vld), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'd0);
`ifdef C17_MISR_EN
    chk("rst_misr", 32'(misr_sig), 32'hFFFF);
`endif

    // Responses offered in IDLE are not accepted.
    resp_valid = 1'b1; resp_data = 2'b11;
    repeat (3) tick();
    resp_valid = 1'b0;
    chk("idle_cnt", 32'(fail_cnt), 32'd0);
    chk("idle_ready", 32'(resp_ready), 32'd0);

    load_gold(1'b0);
    for (int i = 0; i < NUM_PAT; i++) resp_q[i] = RESP_W'(i % 4);
`ifdef C17_MISR_EN
    // Single accept of 2'b01 from the cleared signature.
    resp_q[0] = 2'b01; gold_m[0] = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    resp_valid = 1'b1; resp_data = 2'b01; tick(); resp_valid = 1'b0;
    chk("misr_one_accept", 32'(misr_sig), 32'hFFFF);
    abort = 1'b1; tick(); abort = 1'b0;
    resp_q[0] = 2'b00;
`endif
    do_run(1'b0, -1, 1'b0);

    // DONE ignores responses and holds results.
    resp_valid = 1'b1; resp_data = 2'b11;
    repeat (3) tick();
    resp_valid = 1'b0;
    chk("done_hold_cnt", 32'(fail_cnt), 32'd0);
    chk("done_hold", 32'(done), 32'd1);
    chk("done_ready", 32'(resp_ready), 32'd0);

    resp_q[5] = 2'b00; resp_q[20] = gold_m[20] ^ 2'b10;
    do_run(1'b0, -1, 1'b0);

    for (int i = 0; i < NUM_PAT; i++) resp_q[i] = RESP_W'($urandom_range(0, 3));
    do_run(1'b1, -1, 1'b1);
    for (int i = 0; i < NUM_PAT; i++) resp_q[i] = gold_m[i];
    do_run(1'b1, -1, 1'b0);

    resp_q[3] = ~gold_m[3]; resp_q[10] = ~gold_m[10]; resp_q[12] = ~gold_m[12];
    do_run(1'b0, 10, 1'b0);
    tick();
    chk("abort_hold_cnt", 32'(fail_cnt), 32'd1);
    chk("abort_idle_ready", 32'(resp_ready), 32'd0);

    for (int i = 0; i < NUM_PAT; i++) resp_q[i] = gold_m[i] ^ 2'b01;
    do_run(1'b0, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      load_gold(1'b1);
      for (int i = 0; i < NUM_PAT; i++) resp_q[i] = ($urandom_range(0, 4) == 0) ? ~gold_m[i] : gold_m[i];
      do_run(1'b1, -1, 1'b0);
    end

    // Reset in the middle of a run drops partial results but keeps the table.
    start = 1'b1; tick(); start = 1'b0;
    resp_valid = 1'b1; resp_data = ~gold_m[0];
    repeat (5) tick();
    resp_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_cnt", 32'(fail_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_PAT; i++) resp_q[i] = gold_m[i];
    do_run(1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
